// File: rtl/traffic_lights_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_lights_pkg
// Description : Light encodings, controller state type and per-street decode.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_lights_pkg;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    function automatic logic [1:0] light_a(input state_t s);
        case (s)
            S0:      light_a = GREEN;
            S1:      light_a = YELLOW;
            default: light_a = RED;
        endcase
    endfunction

    function automatic logic [1:0] light_b(input state_t s);
        case (s)
            S2:      light_b = GREEN;
            S3:      light_b = YELLOW;
            default: light_b = RED;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/yellow_timer.sv
`default_nettype none
// ============================================================================
// Module      : yellow_timer
// Description : Yellow-phase dwell counter; done flags the final dwell cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module yellow_timer #(
    parameter int unsigned YELLOW_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    localparam logic [7:0] C_LAST = 8'(YELLOW_CYCLES - 1);

    logic [7:0] r_count;

    assign done = (r_count == C_LAST);

    // Counter parks on its last value so done cannot wrap and re-fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 8'd0;
        end else if (start) begin
            r_count <= 8'd0;
        end else if (!done) begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_lights_fsm.sv
`default_nettype none
// ============================================================================
// Module      : traffic_lights_fsm
// Description : Two-street Moore traffic light controller with timed yellow.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_lights_fsm
    import traffic_lights_pkg::*;
#(
    parameter int unsigned YELLOW_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       TA,
    input  logic       TB,
    output logic [1:0] LA,
    output logic [1:0] LB
);

    state_t r_state;
    state_t w_next;
    logic   w_start;
    logic   w_done;

    yellow_timer #(
        .YELLOW_CYCLES (YELLOW_CYCLES)
    ) u_yellow_timer (
        .clk   (clk),
        .reset (reset),
        .start (w_start),
        .done  (w_done)
    );

    always_comb begin
        w_next = S0;
        case (r_state)
            S0:      w_next = TA     ? S0 : S1;
            S1:      w_next = w_done ? S2 : S1;
            S2:      w_next = TB     ? S2 : S3;
            S3:      w_next = w_done ? S0 : S3;
            default: w_next = S0;
        endcase
    end

    // Timer restarts on the edge that enters either yellow phase.
    assign w_start = ((w_next == S1) && (r_state != S1)) ||
                     ((w_next == S3) && (r_state != S3));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S0;
            LA      <= GREEN;
            LB      <= RED;
        end else begin
            r_state <= w_next;
            LA      <= light_a(w_next);
            LB      <= light_b(w_next);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_lights_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_lights_fsm
// Description : Directed and random checks of traffic_lights_fsm (Y=1, Y=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_lights_fsm;

    localparam logic [3:0] C_AG = 4'b0010;  // {LA,LB} = GREEN, RED
    localparam logic [3:0] C_AY = 4'b0110;  // YELLOW, RED
    localparam logic [3:0] C_BG = 4'b1000;  // RED, GREEN
    localparam logic [3:0] C_BY = 4'b1001;  // RED, YELLOW

    logic       clk = 1'b0;
    logic       reset, TA, TB;
    logic [1:0] LA, LB;
    logic       reset3, TA3, TB3;
    logic [1:0] LA3, LB3;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    traffic_lights_fsm #(.YELLOW_CYCLES(1)) dut (
        .clk (clk), .reset (reset), .TA (TA), .TB (TB), .LA (LA), .LB (LB)
    );

    traffic_lights_fsm #(.YELLOW_CYCLES(3)) dut3 (
        .clk (clk), .reset (reset3), .TA (TA3), .TB (TB3), .LA (LA3), .LB (LB3)
    );

    function automatic logic legal(input logic [3:0] v);
        return (v == C_AG) || (v == C_AY) || (v == C_BG) || (v == C_BY);
    endfunction

    always @(negedge clk) begin
        assert (legal({LA, LB}) && legal({LA3, LB3}))
            else $error("illegal light pair %b %b", {LA, LB}, {LA3, LB3});
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference lights for Y=1: states 0..3 map to the four legal pairs.
    function automatic logic [3:0] ref_lights(input int s);
        case (s)
            0:       return C_AG;
            1:       return C_AY;
            2:       return C_BG;
            default: return C_BY;
        endcase
    endfunction

    function automatic int ref_next(input int s, input logic ta, input logic tb);
        case (s)
            0:       return ta ? 0 : 1;
            1:       return 2;
            2:       return tb ? 2 : 3;
            default: return 0;
        endcase
    endfunction

    initial begin
        int m, mn;
        reset = 1'b1; TA = 1'b1; TB = 1'b0;
        reset3 = 1'b1; TA3 = 1'b1; TB3 = 1'b1;

        #1 check("reset_pre_edge", {LA, LB}, C_AG);
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_held", {LA, LB}, C_AG);
        end

        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("a_green_hold", {LA, LB}, C_AG);
        end
        TA = 1'b0;
        step(); check("a_yellow", {LA, LB}, C_AY);
        step(); check("b_green", {LA, LB}, C_BG);

        TB = 1'b1; TA = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("b_green_hold", {LA, LB}, C_BG);
        end
        TB = 1'b0;
        step(); check("b_yellow", {LA, LB}, C_BY);
        step(); check("a_green_again", {LA, LB}, C_AG);

        // Asynchronous reset while street B is green.
        TA = 1'b0;
        step(); check("to_s1", {LA, LB}, C_AY);
        step(); check("to_s2", {LA, LB}, C_BG);
        @(negedge clk);
        reset = 1'b1;
        #1 check("async_reset_s2", {LA, LB}, C_AG);
        step(); check("reset_hold_ta0", {LA, LB}, C_AG);
        reset = 1'b0; TA = 1'b1;
        step(); check("post_reset_s0", {LA, LB}, C_AG);

        // Asynchronous reset in the middle of yellow.
        TA = 1'b0;
        step(); check("yellow_before_reset", {LA, LB}, C_AY);
        #2 reset = 1'b1;
        #1 check("async_reset_s1", {LA, LB}, C_AG);
        step();
        reset = 1'b0; TA = 1'b1;
        step(); check("no_yellow_after_reset", {LA, LB}, C_AG);

        // Random traffic against the reference model.
        m = 0;
        for (int i = 0; i < 1000; i++) begin
            TA = 1'($urandom_range(0, 1));
            TB = 1'($urandom_range(0, 1));
            mn = ref_next(m, TA, TB);
            step();
            m = mn;
            check("random", {LA, LB}, ref_lights(m));
        end

        // Three-cycle yellow on the second instance.
        step();
        reset3 = 1'b0;
        step(); check("y3_s0", {LA3, LB3}, C_AG);
        TA3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("y3_a_yellow", {LA3, LB3}, C_AY);
        end
        TB3 = 1'b1;
        step(); check("y3_b_green", {LA3, LB3}, C_BG);
        step(); check("y3_b_green_hold", {LA3, LB3}, C_BG);
        TB3 = 1'b0; TA3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("y3_b_yellow", {LA3, LB3}, C_BY);
        end
        step(); check("y3_a_green", {LA3, LB3}, C_AG);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_lights_fsm.md
TRAFFIC_LIGHTS_FSM -- requirements
Module: traffic_lights_fsm

Interface
REQ-001 SHALL have one parameter: YELLOW_CYCLES, default 1, number of clock cycles each yellow phase lasts (legal range 1..255).
REQ-002 SHALL have port `clk`, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port `reset`, input, 1 bit: reset is asynchronous and active-high.
REQ-004 SHALL have port `TA`, input, 1 bit: traffic present on street A.
REQ-005 SHALL have port `TB`, input, 1 bit: traffic present on street B.
REQ-006 SHALL have port `LA`, output, 2 bits: street A light.
REQ-007 SHALL have port `LB`, output, 2 bits: street B light.
REQ-008 SHALL use light encoding GREEN=2'b00, YELLOW=2'b01, RED=2'b10; 2'b11 is never driven.

Function
REQ-009 SHALL be a Moore machine with four states S0..S3; LA/LB decode from state only, with no combinational path from TA/TB.
REQ-010 SHALL drive these outputs per state:
- S0: LA=GREEN, LB=RED.
- S1: LA=YELLOW, LB=RED.
- S2: LA=RED, LB=GREEN.
- S3: LA=RED, LB=YELLOW.
REQ-011 S0 transitions: TA=1 -> stay S0; TA=0 -> S1; TB ignored.
REQ-012 S1 SHALL last exactly YELLOW_CYCLES cycles, then go to S2 regardless of TA/TB.
REQ-013 S2 transitions: TB=1 -> stay S2; TB=0 -> S3; TA ignored.
REQ-014 S3 SHALL last exactly YELLOW_CYCLES cycles, then go to S0 regardless of TA/TB.
REQ-015 The yellow dwell counter SHALL load 0 on entry to S1/S3 and increment each cycle; exit occurs on the cycle the count equals YELLOW_CYCLES-1.
REQ-016 Both streams SHALL never be non-RED simultaneously in any cycle.
REQ-017 An unreachable or corrupted state encoding SHALL transition to S0 on the next edge.
REQ-018 With YELLOW_CYCLES=1, the sequence S0->S1->S2 SHALL take exactly 2 edges after TA falls (sampled low).

Reset
REQ-019 Asserting reset SHALL immediately (asynchronously, without a clock edge) force state S0, LA=GREEN, LB=RED, and clear the dwell counter.
REQ-020 While reset is high, the state SHALL hold S0; the first transition is evaluated on the first rising edge after deassertion.
REQ-021 Reset asserted mid-phase (for example in S2 or mid-yellow) SHALL abort the phase and return to S0 with no yellow step.

Structure
REQ-022 A shared package traffic_lights_pkg SHALL hold:
- the light encoding constants GREEN/YELLOW/RED;
- the state enum (S0..S3, 2-bit).
REQ-023 The yellow dwell counter SHALL be one sub-module, yellow_timer:
- inputs: clk, reset, start, YELLOW_CYCLES;
- output: done.
REQ-024 The top SHALL contain the state register, next-state logic and output decode only.

Verification
REQ-025 Scenario 1: reset=1 held while TA=1 and clocks run -> LA=2'b00, LB=2'b10 on every sample, including before the first edge.
REQ-026 Scenario 2: release reset, TA=1 for 5 cycles -> LA=GREEN, LB=RED throughout; then TA=0 -> after edge 1 LA=YELLOW, LB=RED; after edge 2 LA=RED, LB=GREEN.
REQ-027 Scenario 3: in S2 with TB=1 for 4 cycles -> LB stays GREEN; TB=0 -> after edge 1 LB=YELLOW, LA=RED; after edge 2 LA=GREEN, LB=RED.
REQ-028 Scenario 4: drive to S2, then assert reset between clock edges -> LA=GREEN, LB=RED within the same cycle, before the next rising edge.
REQ-029 Scenario 5: YELLOW_CYCLES=3, TA=0 from S0 -> LA=YELLOW for exactly 3 consecutive cycles, then LA=RED, LB=GREEN.
REQ-030 Scenario 6: random TA/TB for 1000 cycles -> assertion that {LA,LB} is always one of {00,10}, {01,10}, {10,00}, {10,01}, and never 2'b11.
